// File: rtl/key_event_gen.sv
// Multi-channel key front end: 2-flop sync, programmable debounce, and
// registered press / release / long-press / auto-repeat pulses per channel.

module key_event_lane #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int REPEAT_CYCLES   = 3000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    input  logic i_en,
    output logic o_level,
    output logic o_level_nxt,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);
    localparam logic    REL_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int      DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int      HMAX    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int      HW      = $clog2(HMAX + 1);
    localparam int      REP_TH  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] LONG_END = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_END  = HW'(REP_TH);
    localparam logic [HW-1:0] HOLD_SAT = {HW{1'b1}};

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    logic          r_sync1, r_sync2;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold;
    state_t        r_state;

    logic w_pressed, w_diff, w_toggle, w_rise, w_fall;
    logic [HW-1:0] w_hold_inc;

    assign w_pressed   = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_diff      = (w_pressed != o_level);
    assign w_toggle    = w_diff && (r_db_cnt == DB_MAX);
    assign w_rise      = w_toggle && !o_level;
    assign w_fall      = w_toggle && o_level;
    assign o_level_nxt = o_level ^ w_toggle;
    assign w_hold_inc  = (r_hold == HOLD_SAT) ? r_hold : r_hold + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= REL_RAW;
            r_sync2   <= REL_RAW;
            r_db_cnt  <= '0;
            r_hold    <= '0;
            r_state   <= IDLE;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            o_repeat  <= 1'b0;

            // Count only while the synced value disagrees; any agreement restarts the window.
            if (!w_diff || w_toggle) r_db_cnt <= '0;
            else                     r_db_cnt <= r_db_cnt + 1'b1;
            o_level <= o_level_nxt;

            case (r_state)
                IDLE: begin
                    r_hold <= '0;
                    if (w_rise) begin
                        r_state <= PRESSED;
                        o_press <= i_en;
                    end
                end
                PRESSED: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_hold    <= '0;
                        o_release <= i_en;
                    end else if (r_hold == LONG_END) begin
                        r_state <= LONG;
                        r_hold  <= '0;
                        o_long  <= i_en;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_hold    <= '0;
                        o_release <= i_en;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (r_hold == REP_END) begin
                            r_hold   <= '0;
                            o_repeat <= i_en;
                        end else begin
                            r_hold <= w_hold_inc;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end
endmodule

module key_event_gen #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int REPEAT_CYCLES   = 3000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_keys,
    input  logic [N_KEYS-1:0] i_en,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat,
    output logic              o_any
);
    logic [N_KEYS-1:0] w_level_nxt;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_event_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_key       (i_keys[g]),
            .i_en        (i_en[g]),
            .o_level     (o_level[g]),
            .o_level_nxt (w_level_nxt[g]),
            .o_press     (o_press[g]),
            .o_release   (o_release[g]),
            .o_long      (o_long[g]),
            .o_repeat    (o_repeat[g])
        );
    end

    // Registered from the lanes' next-level so o_any tracks o_level cycle-exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_any <= 1'b0;
        else       o_any <= |w_level_nxt;
    end
endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen; expected events are queued with their
// target cycle when stimulus is driven and checked every cycle at negedge.

module tb_key_event_gen;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int RP = 8;
    localparam int LAT = DB + 3;  // negedge-drive cycle to output cycle

    typedef enum int {E_LSET, E_LCLR, E_PRESS, E_REL, E_LONG, E_REP, E_CLRALL} ekind_t;
    typedef struct {int cyc; ekind_t kind; int ch;} ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] keys, en;
    logic [N-1:0] level, press, rel, lng, rep;
    logic         any;

    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    bit      chk_en = 1'b0;
    ev_t     q[$];
    logic [N-1:0] exp_level = '0;

    key_event_gen #(.N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG),
                    .REPEAT_CYCLES(RP), .ACTIVE_LOW(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_keys(keys), .i_en(en),
        .o_level(level), .o_press(press), .o_release(rel), .o_long(lng),
        .o_repeat(rep), .o_any(any));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input ekind_t k, input int ch);
        ev_t e;
        e.cyc = c; e.kind = k; e.ch = ch;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: pop every event due this cycle, then compare all outputs.
    always @(negedge clk) begin
        logic [N-1:0] ep, er, el, erp;
        ep = '0; er = '0; el = '0; erp = '0;
        if (chk_en) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    case (q[i].kind)
                        E_LSET:   exp_level[q[i].ch] = 1'b1;
                        E_LCLR:   exp_level[q[i].ch] = 1'b0;
                        E_PRESS:  ep[q[i].ch]  = 1'b1;
                        E_REL:    er[q[i].ch]  = 1'b1;
                        E_LONG:   el[q[i].ch]  = 1'b1;
                        E_REP:    erp[q[i].ch] = 1'b1;
                        E_CLRALL: exp_level = '0;
                        default:  ;
                    endcase
                    q.delete(i);
                end else if (q[i].cyc < cyc) begin
                    checks++;
                    failures++;
                    $error("FAIL stale_event cyc=%0d observed=none expected=kind%0d@%0d",
                           cyc, q[i].kind, q[i].cyc);
                    q.delete(i);
                end
            end
            chk("level",   level, exp_level);
            chk("press",   press, ep);
            chk("release", rel,   er);
            chk("long",    lng,   el);
            chk("repeat",  rep,   erp);
            chk("any",     {{(N-1){1'b0}}, any}, {{(N-1){1'b0}}, |exp_level});
        end
    end

    initial begin
        int p, r;
        rst = 1'b1; keys = '1; en = '1;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle with all keys released.
        tick(50);

        // Key 0: press, long, three repeats, release before the fourth repeat.
        keys[0] = 1'b0;
        p = cyc + LAT;
        push(p, E_LSET, 0); push(p, E_PRESS, 0);
        push(p + LG, E_LONG, 0);
        push(p + LG + RP, E_REP, 0);
        push(p + LG + 2*RP, E_REP, 0);
        push(p + LG + 3*RP, E_REP, 0);
        tick(p + LG + 3*RP - cyc);
        keys[0] = 1'b1;
        push(cyc + LAT, E_LCLR, 0); push(cyc + LAT, E_REL, 0);
        tick(LAT + 2*RP);

        // Key 1: 3-cycle glitch must be rejected.
        keys[1] = 1'b0;
        tick(3);
        keys[1] = 1'b1;
        tick(15);

        // Keys 2 and 3 together, channel 3 events masked.
        en[3] = 1'b0;
        keys[3:2] = 2'b00;
        p = cyc + LAT;
        push(p, E_LSET, 2); push(p, E_LSET, 3); push(p, E_PRESS, 2);
        tick(LAT + 8);
        keys[3:2] = 2'b11;
        push(cyc + LAT, E_LCLR, 2); push(cyc + LAT, E_LCLR, 3);
        push(cyc + LAT, E_REL, 2);
        tick(LAT + 5);
        en[3] = 1'b1;

        // Key 0 hold interrupted by a one-cycle reset, then re-detected.
        keys[0] = 1'b0;
        p = cyc + LAT;
        push(p, E_LSET, 0); push(p, E_PRESS, 0);
        tick(p + 10 - cyc);
        rst = 1'b1;
        r = cyc + 1;
        push(r, E_CLRALL, 0);
        tick(1);
        rst = 1'b0;
        p = r + LAT;
        push(p, E_LSET, 0); push(p, E_PRESS, 0);
        tick(p + 5 - cyc);
        keys[0] = 1'b1;
        push(cyc + LAT, E_LCLR, 0); push(cyc + LAT, E_REL, 0);
        tick(LAT + 10);

        chk_en = 1'b0;
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drained observed=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Parametrised, multi-channel key front end. Generalises the single-key debouncer that feeds the recorder's Record/Play/Stop controls.
- Per channel it synchronises a raw active-low pushbutton, debounces it with a programmable window, and emits one-cycle press, release, long-press and auto-repeat pulses.
- Sits between the board KEY/SW pins and the recorder control core, in the 12 MHz audio clock domain.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept a level change (10 ms at 12 MHz). Must be ≥1.
- LONG_CYCLES, 12000000, hold time from accepted press to the o_long pulse (1 s). Must be ≥1.
- REPEAT_CYCLES, 3000000, period of o_repeat pulses after o_long (0.25 s). 0 disables repeat.
- ACTIVE_LOW, 1, 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".

Ports:
- i_clk  input  1  system clock (CLK_12M)
- i_rst  input  1  synchronous reset, active-high
- i_keys  input  N_KEYS  raw asynchronous key pins
- i_en  input  N_KEYS  per-channel event enable; level tracking continues when low
- o_level  output  N_KEYS  debounced state, 1 = pressed
- o_press  output  N_KEYS  1-cycle pulse on accepted press
- o_release  output  N_KEYS  1-cycle pulse on accepted release
- o_long  output  N_KEYS  1-cycle pulse when the hold reaches LONG_CYCLES
- o_repeat  output  N_KEYS  1-cycle pulse every REPEAT_CYCLES after o_long while held
- o_any  output  1  OR of o_level

Behaviour:
- Reset (i_rst high at a clock edge):
  - Synchroniser flops load the "released" raw value.
  - All counters go to 0; every FSM goes to IDLE.
  - Every output is 0 on the cycle after the edge.
  - Reset mid-hold discards any pending long/repeat pulse. No o_release is generated.
- Synchroniser: 2 flops per channel; the result is then normalised to pressed = 1 using ACTIVE_LOW.
- Debounce counter (per channel, width $clog2(DEBOUNCE_CYCLES+1)):
  - Counts up while the synchronised value differs from o_level.
  - Clears to 0 on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, o_level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Latency: from the first clock edge sampling the new raw level to o_level changing is exactly DEBOUNCE_CYCLES+2 cycles.
- Per-channel FSM:
  - IDLE → PRESSED on o_level 0→1. o_press pulses in the same cycle o_level rises. The hold counter is cleared.
  - PRESSED: the hold counter increments each cycle. When it reaches LONG_CYCLES, o_long pulses, the counter clears and the FSM goes to LONG.
  - LONG: if REPEAT_CYCLES > 0, the counter increments. Each time it reaches REPEAT_CYCLES, o_repeat pulses and the counter clears. The first o_repeat comes REPEAT_CYCLES after o_long.
  - PRESSED or LONG → IDLE on o_level 1→0. o_release pulses in the same cycle o_level falls. No o_long or o_repeat is issued in that cycle or later.
- Hold counter width: $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1). It saturates and never wraps.
- Pulse rules:
  - o_press/o_long/o_repeat/o_release are mutually exclusive per channel per cycle.
  - Channels are fully independent; simultaneous events on several channels all assert in the same cycle.
- i_en[k] low:
  - Masks the o_press/o_release/o_long/o_repeat outputs of channel k only.
  - o_level, the FSM and the counters keep running.
  - Raising i_en mid-hold does not replay missed pulses.
- All outputs are registered; no combinational path from input pins to outputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, N_KEYS=4, ACTIVE_LOW=1):
- Reset, then hold i_keys=4'b1111 for 50 cycles → all outputs 0; o_any=0.
- i_keys[0] goes to 0 at edge k and stays low → o_level[0]=1 and o_press[0]=1 for exactly one cycle, 6 cycles after k. o_release/o_long stay 0 during the first 19 cycles of the hold.
- Continue holding key 0 → o_long[0] 20 cycles after o_press. o_repeat[0] at +28, +36, +44. Release → o_release[0] 6 cycles after the raw rise, and no further repeat.
- Glitch: i_keys[1] low for 3 cycles, then high → o_level[1] and all pulses for channel 1 stay 0 throughout.
- Keys 2 and 3 pressed on the same edge, with i_en[3]=0 → o_press[2] pulses. o_press[3] stays 0. o_level[3]=1 and o_any=1.
- Assert i_rst for 1 cycle 10 cycles into a key-0 hold → next cycle all outputs 0, no o_release. Key still low → o_press[0] again 6 cycles after the reset deasserts.
